// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with first-word-fall-through output FIFO and per-character error flags.
// Break detection is compiled in when UART_RX_BREAK_DET_EN is defined; otherwise break_det is tied 0.
module uart_rx_param #(
    parameter int unsigned CLOCK_RATE = 200_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd_i,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frm_err,
    output logic                          par_err,
    output logic                          ovr_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          break_det
);
    localparam int unsigned DIV   = (CLOCK_RATE + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;
`ifdef UART_RX_BREAK_DET_EN
    localparam bit BREAK_EN = 1'b1;
`else
    localparam bit BREAK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

    typedef struct packed {
        logic                 frm;
        logic                 par;
        logic [DATA_BITS-1:0] data;
    } rx_word_t;

    logic [1:0]           sync_q;
    logic                 rxd_s;
    logic [DIV_W-1:0]     div_q;
    logic                 tick;

    state_t               state_q, state_d;
    logic [OS_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 frm_q, frm_d;
    logic                 perr_q, perr_d;
    logic                 zero_q, zero_d;
    logic                 armed_q, armed_d;
    logic                 brk_q, brk_d;
    logic                 push_c;
    logic                 bit_done;
    rx_word_t             push_word;

    rx_word_t             mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level_q, level_d;
    logic                 valid_q, ovr_q;
    logic                 pop, full, wr_en;

    assign rxd_s = sync_q[1];
    assign tick  = (div_q == DIV_W'(DIV - 1));

    // Synchroniser and free-running oversample tick divider
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            div_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
            div_q  <= tick ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            frm_q   <= 1'b0;
            perr_q  <= 1'b0;
            zero_q  <= 1'b0;
            armed_q <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            frm_q   <= frm_d;
            perr_q  <= perr_d;
            zero_q  <= zero_d;
            armed_q <= armed_d;
            brk_q   <= brk_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        frm_d    = frm_q;
        perr_d   = perr_q;
        zero_d   = zero_q;
        brk_d    = brk_q;
        push_c   = 1'b0;
        armed_d  = armed_q | (tick & rxd_s);
        bit_done = (cnt_q == OS_W'(OVERSAMPLE - 1));
        if (tick && rxd_s) brk_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && !rxd_s && armed_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
                        if (rxd_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            cnt_d   = '0;
                            bit_d   = '0;
                            frm_d   = 1'b0;
                            perr_d  = 1'b0;
                            zero_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + OS_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_done) begin
                        cnt_d   = '0;
                        shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
                        zero_d  = zero_q & ~rxd_s;
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                            bit_d   = '0;
                            state_d = (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + OS_W'(1);
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    if (bit_done) begin
                        cnt_d   = '0;
                        perr_d  = ((^shreg_q) ^ rxd_s) != (PARITY == 1);
                        zero_d  = zero_q & ~rxd_s;
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + OS_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_done) begin
                        cnt_d  = '0;
                        frm_d  = frm_q | ~rxd_s;
                        zero_d = zero_q & ~rxd_s;
                        if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                            bit_d = '0;
                            // An all-zero frame is a line break, not a character
                            if (BREAK_EN && zero_q && !rxd_s) begin
                                brk_d   = 1'b1;
                                state_d = WAIT_HIGH;
                            end else begin
                                push_c  = 1'b1;
                                state_d = rxd_s ? IDLE : WAIT_HIGH;
                            end
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + OS_W'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (tick && rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign push_word = '{frm: frm_q | ~rxd_s, par: perr_q, data: shreg_q};

    assign pop     = valid_q & rx_ready;
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign wr_en   = push_c & (~full | pop);
    assign level_d = level_q + LW'(wr_en) - LW'(pop);

    // Receive FIFO; a push into a full FIFO only succeeds alongside a pop
    always_ff @(posedge clk) begin
        if (rst) begin
            mem     <= '{default: '0};
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level_q <= level_d;
            valid_q <= (level_d != '0);
            ovr_q   <= push_c & full & ~pop;
        end
    end

    assign rx_data    = mem[rd_ptr].data;
    assign frm_err    = mem[rd_ptr].frm;
    assign par_err    = mem[rd_ptr].par;
    assign rx_valid   = valid_q;
    assign fifo_level = level_q;
    assign ovr_err    = ovr_q;
    assign break_det  = brk_q;

endmodule
